// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-sequencer types and constants
package mips_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_NOP   = 2'd1,
        CAUSE_WRAP  = 2'd2,
        CAUSE_ABORT = 2'd3
    } halt_cause_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/mips_byte_word_read.sv
// mips_byte_word_read: combinational little-endian 32-bit word assembler over a byte image
// Ports: mem_i (byte image), addr_i (byte address, wraps modulo MEM_BYTES), word_o (assembled word)
module mips_byte_word_read #(
    parameter int MEM_BYTES = 256,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic [7:0]    mem_i [MEM_BYTES-1:0],
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   word_o
);

    assign word_o = {mem_i[addr_i + AW'(3)], mem_i[addr_i + AW'(2)],
                     mem_i[addr_i + AW'(1)], mem_i[addr_i]};

endmodule

// File: rtl/mips_fetch_sequencer.sv
// mips_fetch_sequencer: instruction fetch and run control with NOP-run, wrap and abort halting
// Ports: clk/reset, instruction_mem byte image, start/abort run control, redirect_valid/redirect_pc,
//        instr_valid/instr_ready/instr/pc fetch handshake, halted/halt_cause status,
//        cycle_count/retired_count saturating run statistics
module mips_fetch_sequencer
    import mips_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int NOP_HALT  = 3,
    parameter int WRAP_HALT = 1,
    parameter int CNT_W     = 32,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       instruction_mem [MEM_BYTES-1:0],
    input  logic             start,
    input  logic             abort,
    input  logic             redirect_valid,
    input  logic [AW-1:0]    redirect_pc,
    input  logic             instr_ready,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [AW-1:0]    pc,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    fetch_state_e     state_q, state_d;
    halt_cause_e      cause_q, cause_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [3:0]       nop_q, nop_d, nop_inc;
    logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;
    logic             wrap_hit;

    mips_byte_word_read #(.MEM_BYTES(MEM_BYTES)) u_read (
        .mem_i  (instruction_mem),
        .addr_i (pc_q),
        .word_o (instr)
    );

    assign nop_inc  = (instr == NOP_WORD) ? nop_q + 4'd1 : 4'd0;
    assign wrap_hit = (WRAP_HALT != 0) && (pc_q == AW'(MEM_BYTES - 4));

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        nop_d   = nop_q;
        cyc_d   = cyc_q;
        ret_d   = ret_q;
        if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                cause_d = CAUSE_NONE;
                pc_d    = '0;
                nop_d   = '0;
                cyc_d   = '0;
                ret_d   = '0;
            end
        end else begin
            cyc_d = &cyc_q ? cyc_q : cyc_q + 1'b1;
            // abort drops any same-cycle handshake, so retire/pc updates sit under the else
            if (abort) begin
                state_d = HALTED;
                cause_d = CAUSE_ABORT;
            end else begin
                if (instr_ready) begin
                    ret_d = &ret_q ? ret_q : ret_q + 1'b1;
                    nop_d = nop_inc;
                    pc_d  = pc_q + AW'(4);
                end
                // halting words keep pc on their own address, even over a redirect
                if (instr_ready && nop_inc == 4'(NOP_HALT)) begin
                    state_d = HALTED;
                    cause_d = CAUSE_NOP;
                    pc_d    = pc_q;
                end else if (instr_ready && wrap_hit) begin
                    state_d = HALTED;
                    cause_d = CAUSE_WRAP;
                    pc_d    = pc_q;
                end else if (redirect_valid) begin
                    pc_d  = redirect_pc & ~AW'(3);
                    nop_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            pc_q    <= '0;
            nop_q   <= '0;
            cyc_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            nop_q   <= nop_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
        end
    end

    assign instr_valid   = state_q == RUN;
    assign halted        = state_q == HALTED;
    assign halt_cause    = cause_q;
    assign pc            = pc_q;
    assign cycle_count   = cyc_q;
    assign retired_count = ret_q;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// tb_mips_fetch_sequencer: directed scenarios plus randomized run checked against a behavioural model
module tb_mips_fetch_sequencer;

    localparam int MB = 32;
    localparam int NOP_HALT = 3;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic        clk = 0;
    logic        rst = 1, start = 0, abort = 0, redir = 0, ready = 0;
    logic [4:0]  rpc = 0;
    logic [7:0]  mem   [MB-1:0];
    logic [7:0]  mem_b [15:0];

    logic        instr_valid, halted;
    logic [31:0] instr;
    logic [4:0]  pc;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count, retired_count;

    logic        b_valid, b_halted;
    logic [31:0] b_instr;
    logic [3:0]  b_pc;
    logic [1:0]  b_cause;
    logic [31:0] b_cyc, b_ret;

    int n_vec = 0, n_bad = 0;

    int     m_state = 0, m_pc = 0, m_nop = 0, m_cause = 0;
    longint m_cyc = 0, m_ret = 0;

    logic [31:0] q [$];
    logic [31:0] exp1 [5] = '{32'h200A000A, 32'h200C000B, 32'h0, 32'h0, 32'h0};

    always #5 clk = ~clk;

    mips_fetch_sequencer #(.MEM_BYTES(MB), .NOP_HALT(NOP_HALT), .WRAP_HALT(1), .CNT_W(32)) dut (
        .clk(clk), .reset(rst), .instruction_mem(mem), .start(start), .abort(abort),
        .redirect_valid(redir), .redirect_pc(rpc), .instr_ready(ready),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .halted(halted),
        .halt_cause(halt_cause), .cycle_count(cycle_count), .retired_count(retired_count)
    );

    mips_fetch_sequencer #(.MEM_BYTES(16), .NOP_HALT(NOP_HALT), .WRAP_HALT(0), .CNT_W(32)) dut_b (
        .clk(clk), .reset(rst), .instruction_mem(mem_b), .start(start), .abort(abort),
        .redirect_valid(redir), .redirect_pc(rpc[3:0]), .instr_ready(ready),
        .instr_valid(b_valid), .instr(b_instr), .pc(b_pc), .halted(b_halted),
        .halt_cause(b_cause), .cycle_count(b_cyc), .retired_count(b_ret)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input int p);
        return {mem[(p + 3) % MB], mem[(p + 2) % MB], mem[(p + 1) % MB], mem[p % MB]};
    endfunction

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic m_clear();
        m_pc = 0; m_nop = 0; m_cause = 0; m_cyc = 0; m_ret = 0;
    endtask

    task automatic model_step();
        int n;
        if (rst) begin
            m_state = 0;
            m_clear();
        end else if (m_state != 1) begin
            if (start) begin
                m_state = 1;
                m_clear();
            end
        end else begin
            m_cyc = sat(m_cyc + 1);
            if (abort) begin
                m_state = 2; m_cause = 3;
            end else if (ready) begin
                m_ret = sat(m_ret + 1);
                n = (m_word(m_pc) == 0) ? m_nop + 1 : 0;
                if (n == NOP_HALT) begin
                    m_state = 2; m_cause = 1;
                end else if (m_pc == MB - 4) begin
                    m_state = 2; m_cause = 2;
                end else if (redir) begin
                    m_pc = int'(rpc) - int'(rpc) % 4; m_nop = 0;
                end else begin
                    m_pc = (m_pc + 4) % MB; m_nop = n;
                end
            end else if (redir) begin
                m_pc = int'(rpc) - int'(rpc) % 4; m_nop = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("valid", instr_valid, m_state == 1);
        chk("halted", halted, m_state == 2);
        chk("pc", pc, m_pc);
        chk("instr", instr, m_word(m_pc));
        chk("cause", halt_cause, m_cause);
        chk("cycles", cycle_count, m_cyc);
        chk("retired", retired_count, m_ret);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + i] = w[8*i +: 8];
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < MB; i++) mem[i] = v;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic run_until_halt(input string tag);
        for (int i = 0; i < 100 && !halted; i++) tick();
        chk(tag, halted, 1);
    endtask

    initial begin
        fill_mem(8'h00);
        for (int i = 0; i < 16; i++) mem_b[i] = 8'h01;
        put_word(0, 32'h200A000A);
        put_word(4, 32'h200C000B);
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst_instr", instr, 32'h200A000A);
        chk("rst_valid", instr_valid, 0);

        ready = 1;
        pulse_start();
        for (int i = 0; i < 40 && !halted; i++) begin
            if (instr_valid) q.push_back(instr);
            tick();
        end
        chk("t1_halt", halted, 1);
        chk("t1_len", q.size(), 5);
        for (int i = 0; i < 5 && i < q.size(); i++) chk("t1_seq", q[i], exp1[i]);
        chk("t1_cause", halt_cause, 1);
        chk("t1_ret", retired_count, 5);
        chk("t1_cyc", cycle_count, 5);

        pulse_start();
        for (int k = 1; k <= 40 && !halted; k++) begin
            ready = !(k >= 2 && k <= 4);
            if (k >= 2 && k <= 4) begin
                chk("t2_pc", pc, 4);
                chk("t2_instr", instr, 32'h200C000B);
            end
            tick();
        end
        ready = 1;
        chk("t2_halt", halted, 1);
        chk("t2_ret", retired_count, 5);
        chk("t2_cyc", cycle_count, 8);

        rst = 1;
        tick();
        rst = 0;
        fill_mem(8'h01);
        pulse_start();
        for (int k = 1; k <= 40 && !halted; k++) begin
            if (k == 5) begin
                chk("t3_bpc", b_pc, 0);
                chk("t3_bvalid", b_valid, 1);
            end
            tick();
        end
        chk("t3_halt", halted, 1);
        chk("t3_cause", halt_cause, 2);
        chk("t3_ret", retired_count, 8);
        chk("t3_pc", pc, 28);

        fill_mem(8'h00);
        pulse_start();
        tick();
        redir = 1;
        rpc = 5'h0B;
        tick();
        redir = 0;
        chk("t4_pc", pc, 8);
        run_until_halt("t4_halt");
        chk("t4_cause", halt_cause, 1);
        chk("t4_ret", retired_count, 5);
        chk("t4_pcend", pc, 16);

        fill_mem(8'h01);
        pulse_start();
        tick();
        tick();
        abort = 1;
        tick();
        abort = 0;
        chk("t5_halt", halted, 1);
        chk("t5_cause", halt_cause, 3);
        chk("t5_ret", retired_count, 2);
        pulse_start();
        chk("t5_pc", pc, 0);
        chk("t5_cyc", cycle_count, 0);
        chk("t5_ret0", retired_count, 0);
        chk("t5_cause0", halt_cause, 0);
        chk("t5_valid", instr_valid, 1);

        tick();
        tick();
        chk("t6_pc8", pc, 8);
        rst = 1;
        tick();
        rst = 0;
        chk("t6_valid", instr_valid, 0);
        chk("t6_halted", halted, 0);
        chk("t6_cyc", cycle_count, 0);
        chk("t6_ret", retired_count, 0);

        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0)
                for (int a = 0; a < MB; a += 4)
                    put_word(a, ($urandom % 2 == 0) ? 32'h0 : $urandom);
            start = ($urandom % 8) == 0;
            ready = ($urandom % 4) != 0;
            redir = ($urandom % 10) == 0;
            rpc   = 5'($urandom);
            abort = ($urandom % 40) == 0;
            rst   = ($urandom % 200) == 0;
            tick();
        end
        rst = 0; start = 0; abort = 0; redir = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_fetch_sequencer.md
# mips_fetch_sequencer

Parametrised instruction-fetch and run-control block for the MIPS core. It walks a byte-addressed instruction memory image, assembles 32-bit words, and presents them to the core over a valid/ready handshake. It accepts branch/jump redirects and halts the run on a configurable run of consecutive NOPs, a PC wrap, or an external abort. Cycle and retired-instruction counters expose the run statistics the bench previously computed by hand.

## Interface
- MEM_BYTES, 256: instruction memory size in bytes; power of two, ≥ 8.
- NOP_HALT, 3: consecutive accepted NOP words (instr == 32'h0) that halt the run; 1..15.
- WRAP_HALT, 1: 1 = halt on PC wrap past MEM_BYTES-4; 0 = wrap silently to 0.
- CNT_W, 32: width of cycle and retired counters.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- instruction_mem  in  [7:0] x MEM_BYTES  byte image, unpacked array indexed [MEM_BYTES-1:0].
- start  in  1  begin a run from PC 0; honoured in IDLE and HALTED only.
- abort  in  1  force halt from RUN.
- redirect_valid  in  1  load PC from redirect_pc.
- redirect_pc  in  $clog2(MEM_BYTES)  byte address of the redirect target.
- instr_ready  in  1  core accepts the presented word.
- instr_valid  out  1  instr/pc are valid.
- instr  out  32  fetched word.
- pc  out  $clog2(MEM_BYTES)  byte address of instr.
- halted  out  1  run has ended.
- halt_cause  out  2  0 none, 1 NOP run, 2 wrap, 3 abort.
- cycle_count  out  CNT_W  cycles spent in RUN.
- retired_count  out  CNT_W  accepted words (handshakes).

## Operation
- Word assembly is little-endian: instr = {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}. The read is combinational from the pc register.
- States are IDLE, RUN, and HALTED.
- IDLE: instr_valid=0, halted=0. On start: pc←0, counters and nop_run cleared, →RUN.
- RUN: instr_valid=1 every cycle. cycle_count increments every RUN cycle.
- On handshake (instr_valid && instr_ready):
  - retired_count increments.
  - nop_run ← (instr==0) ? nop_run+1 : 0.
  - pc ← pc+4, modulo MEM_BYTES.
- Halt on NOP run: if the accepted word makes nop_run equal NOP_HALT, →HALTED with cause 1. The halting NOP is counted as retired.
- Halt on wrap: if the handshake is at pc = MEM_BYTES-4 and WRAP_HALT=1, →HALTED with cause 2. If WRAP_HALT=0, pc wraps to 0 and the run continues.
- Redirect: redirect_valid in RUN sets pc ← redirect_pc with bits [1:0] forced to 0.
  - It overrides the pc+4 update of the same cycle, but that cycle's handshake still retires.
  - A redirect clears nop_run.
  - A redirect outside RUN is ignored.
- Abort in RUN: →HALTED with cause 3. Any same-cycle handshake is dropped and not counted.
- Priority in the same cycle: abort > NOP-run halt > wrap halt > redirect > increment. A NOP-run or wrap halt on a cycle that also has redirect_valid halts, and pc holds the halting word's address.
- HALTED: instr_valid=0, halted=1. pc, counters and halt_cause hold. On start: clear counters, halt_cause←0, pc←0, →RUN.
- Counters saturate at all-ones; they do not wrap.

## Timing
- Reset values: state IDLE, pc=0, instr_valid=0, halted=0, halt_cause=0, cycle_count=0, retired_count=0, nop_run=0. instr reflects mem[3:0] combinationally.
- start sampled at edge N gives instr_valid=1 from cycle N+1, with pc=0.
- Handshake latency is 0: the next word is presented the cycle after acceptance.
- If instr_ready is low, instr/pc hold and nop_run is unchanged.
- Halt is visible (halted=1, instr_valid=0) the cycle after the triggering edge.
- reset mid-run wins over every input and returns to IDLE on the next edge.
- start held high continuously from HALTED restarts once per HALTED entry.

## Structure
- A shared package mips_pkg holds:
  - typedef fetch_state_e {IDLE, RUN, HALTED};
  - typedef halt_cause_e;
  - the constant NOP_WORD = 32'h0000_0000.
- One sub-module, mips_byte_word_read: a combinational little-endian 4-byte assembler parametrised on MEM_BYTES, reusable by the data-memory path.

## Test plan
- Program addi $10,$0,10 (0x200A000A), addi $12,$0,11 (0x200C000B), then zeros; NOP_HALT=3; ready always 1.
  - instr sequence 0x200A000A, 0x200C000B, 0, 0, 0.
  - halted the cycle after the third NOP; cause 1; retired=5; cycle_count=5.
- Same program with instr_ready low for cycles 2-4.
  - pc holds at 4 and instr at 0x200C000B during the stall.
  - retired=5 at halt; cycle_count=8.
- MEM_BYTES=16, all words 0x01 (non-NOP), WRAP_HALT=1: halt after the handshake at pc=12; cause 2; retired=4. With WRAP_HALT=0, pc reads 0 on the fifth word.
- Two NOPs, then redirect_valid with redirect_pc=0x0B on the second NOP's handshake.
  - pc becomes 0x08; nop_run cleared.
  - the following words need three fresh NOPs to halt.
- abort asserted together with a handshake on the third instruction: retired=2, cause 3; start then restarts at pc=0 with counters at 0.
- reset asserted mid-run at pc=8: next cycle shows IDLE, instr_valid=0, and all counters 0.
